// File: rtl/axis_video_unpack_if.sv
// Stream bundle for axis_video_unpack: AXI4-Stream video input and the
// FIFO-style image stream toward the blur process.
interface axis_video_unpack_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tuser;
    logic              s_axis_tlast;
    logic [DATA_W-1:0] img_data_stream_din;
    logic              img_data_stream_write;
    logic              img_data_stream_full_n;
    logic              img_data_stream_blk_n;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        input  img_data_stream_full_n,
        output s_axis_tready, img_data_stream_din, img_data_stream_write,
        output img_data_stream_blk_n
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        output img_data_stream_full_n,
        input  s_axis_tready, img_data_stream_din, img_data_stream_write,
        input  img_data_stream_blk_n
    );
endinterface

// File: rtl/axis_video_unpack.sv
// Frame input stage: locks onto SOF, forwards rows x cols pixels to the blur
// FIFO, pads short lines with the last pixel and drains over-long lines.
module axis_video_unpack #(
    parameter int DATA_W = 24,
    parameter int DIM_W  = 12
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    input  logic [DIM_W-1:0] rows,
    input  logic [DIM_W-1:0] cols,
    axis_video_unpack_if.slave vif,
    output logic             err_early_eol,
    output logic             err_late_eol
);
    typedef enum logic [2:0] {IDLE, WAIT_SOF, ROW, PAD, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
    logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic [DATA_W-1:0] last_pix_q, last_pix_d;
    logic              early_q, early_d, late_q, late_d;
    logic              last_col, beat_acc, eor;

    assign last_col      = (col_cnt_q == cols_q - DIM_W'(1));
    assign err_early_eol = early_q;
    assign err_late_eol  = late_q;

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        col_cnt_d  = col_cnt_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        last_pix_d = last_pix_q;
        early_d    = early_q;
        late_d     = late_q;
        beat_acc   = 1'b0;
        eor        = 1'b0;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        ap_idle    = 1'b0;
        vif.s_axis_tready         = 1'b0;
        vif.img_data_stream_write = 1'b0;
        vif.img_data_stream_din   = '0;
        vif.img_data_stream_blk_n = 1'b1;

        case (state_q)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    rows_d    = rows;
                    cols_d    = cols;
                    early_d   = 1'b0;
                    late_d    = 1'b0;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                    state_d   = (rows == '0 || cols == '0) ? DONE : WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                // Junk beats before SOF are swallowed even while the FIFO is full.
                vif.s_axis_tready       = vif.s_axis_tuser ? vif.img_data_stream_full_n : 1'b1;
                vif.img_data_stream_din = vif.s_axis_tdata;
                if (vif.s_axis_tvalid && vif.s_axis_tuser) begin
                    vif.img_data_stream_write = vif.img_data_stream_full_n;
                    vif.img_data_stream_blk_n = vif.img_data_stream_full_n;
                    beat_acc                  = vif.img_data_stream_full_n;
                end
            end
            ROW: begin
                vif.s_axis_tready         = vif.img_data_stream_full_n;
                vif.img_data_stream_din   = vif.s_axis_tdata;
                vif.img_data_stream_write = vif.s_axis_tvalid & vif.img_data_stream_full_n;
                vif.img_data_stream_blk_n = vif.img_data_stream_full_n;
                beat_acc                  = vif.s_axis_tvalid & vif.img_data_stream_full_n;
            end
            PAD: begin
                vif.img_data_stream_din   = last_pix_q;
                vif.img_data_stream_write = vif.img_data_stream_full_n;
                vif.img_data_stream_blk_n = vif.img_data_stream_full_n;
                if (vif.img_data_stream_full_n) begin
                    if (last_col) eor = 1'b1;
                    else          col_cnt_d = col_cnt_q + DIM_W'(1);
                end
            end
            DRAIN: begin
                vif.s_axis_tready = 1'b1;
                if (vif.s_axis_tvalid && vif.s_axis_tlast) eor = 1'b1;
            end
            DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (beat_acc) begin
            if (!last_col) begin
                col_cnt_d = col_cnt_q + DIM_W'(1);
                if (vif.s_axis_tlast) begin
                    early_d    = 1'b1;
                    last_pix_d = vif.s_axis_tdata;
                    state_d    = PAD;
                end else begin
                    state_d    = ROW;
                end
            end else if (vif.s_axis_tlast) begin
                eor = 1'b1;
            end else begin
                late_d  = 1'b1;
                state_d = DRAIN;
            end
        end

        if (eor) begin
            if (row_cnt_q == rows_q - DIM_W'(1)) begin
                state_d = DONE;
            end else begin
                row_cnt_d = row_cnt_q + DIM_W'(1);
                col_cnt_d = '0;
                state_d   = ROW;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            early_q   <= 1'b0;
            late_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            early_q   <= early_d;
            late_q    <= late_d;
        end
    end

    // Frame geometry and pad pixel are only read after a start, so no reset.
    always_ff @(posedge ap_clk) begin
        rows_q     <= rows_d;
        cols_q     <= cols_d;
        last_pix_q <= last_pix_d;
    end
endmodule

// File: tb/tb_axis_video_unpack.sv
// Directed bench for axis_video_unpack: per-cycle vector table plus
// hand-written frame sequences for SOF search, late EOL and mid-frame reset.
module tb_axis_video_unpack;
    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_ready, ap_idle;
    logic [11:0] rows, cols;
    logic        err_early_eol, err_late_eol;

    axis_video_unpack_if #(.DATA_W(24)) vif ();

    axis_video_unpack #(.DATA_W(24), .DIM_W(12)) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_ready      (ap_ready),
        .ap_idle       (ap_idle),
        .rows          (rows),
        .cols          (cols),
        .vif           (vif),
        .err_early_eol (err_early_eol),
        .err_late_eol  (err_late_eol)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic        st;
        logic [11:0] r, c;
        logic        vld, usr, lst, full;
        logic [23:0] dat;
        logic        e_rdy, e_wr;
        logic [23:0] e_din;
        logic        e_blk, e_done, e_idle, e_ee, e_le;
    } vec_t;

    vec_t        vq[$];
    logic [23:0] wq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          n_acc = 0;
    logic        last_rdy, last_wr;

    function automatic vec_t mk(input logic st, input logic [11:0] r, c,
                                input logic vld, usr, lst, full, input logic [23:0] dat,
                                input logic rdy, wr, input logic [23:0] edin,
                                input logic blk, dn, idl, ee, le);
        vec_t v;
        v.st = st; v.r = r; v.c = c; v.vld = vld; v.usr = usr; v.lst = lst;
        v.full = full; v.dat = dat; v.e_rdy = rdy; v.e_wr = wr; v.e_din = edin;
        v.e_blk = blk; v.e_done = dn; v.e_idle = idl; v.e_ee = ee; v.e_le = le;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic st, vld, usr, lst, input logic [23:0] dat);
        @(negedge ap_clk);
        ap_start = st;
        vif.s_axis_tvalid = vld;
        vif.s_axis_tuser  = usr;
        vif.s_axis_tlast  = lst;
        vif.s_axis_tdata  = dat;
        #4;
        last_rdy = vif.s_axis_tready;
        last_wr  = vif.img_data_stream_write;
        if (vif.img_data_stream_write) wq.push_back(vif.img_data_stream_din);
        if (ap_done) n_done++;
        if (vld && vif.s_axis_tready) n_acc++;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0 = n_done;
        int k  = 0;
        while (n_done == d0 && k < budget) begin
            cyc(0, 0, 0, 0, 24'h0);
            k++;
        end
        chk({nm, " done pulse"}, 32'(n_done - d0), 32'd1);
        cyc(0, 0, 0, 0, 24'h0);
    endtask

    task automatic chk_writes(input string nm, input logic [23:0] exp[]);
        chk({nm, " write count"}, 32'(wq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wq.size(); i++)
            chk($sformatf("%s pix%0d", nm, i), 32'(wq[i]), 32'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] exp_sof[], exp_late[], exp_rst[];
        ap_rst = 1'b1; ap_start = 1'b0; rows = '0; cols = '0;
        vif.s_axis_tvalid = 1'b0; vif.s_axis_tuser = 1'b0; vif.s_axis_tlast = 1'b0;
        vif.s_axis_tdata = '0; vif.img_data_stream_full_n = 1'b1;

        // Fields: st r c | vld usr lst full dat | rdy wr din blk done idle ee le
        vq.push_back(mk(1, 2, 4, 0, 0, 0, 1, 24'h0, 0, 0, 24'h0, 1, 0, 1, 0, 0));
        vq.push_back(mk(0, 2, 4, 1, 1, 0, 1, 24'h1, 1, 1, 24'h1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 4, 1, 0, 0, 1, 24'h2, 1, 1, 24'h2, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 4, 1, 0, 0, 1, 24'h3, 1, 1, 24'h3, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 4, 1, 0, 1, 1, 24'h4, 1, 1, 24'h4, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 4, 1, 0, 0, 1, 24'h5, 1, 1, 24'h5, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 4, 1, 1, 0, 1, 24'h6, 1, 1, 24'h6, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 4, 1, 0, 0, 1, 24'h7, 1, 1, 24'h7, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 4, 1, 0, 1, 1, 24'h8, 1, 1, 24'h8, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 2, 4, 0, 0, 0, 1, 24'h0, 0, 0, 24'h0, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 2, 4, 0, 0, 0, 1, 24'h0, 0, 0, 24'h0, 1, 0, 1, 0, 0));
        // 1x4 frame with FIFO backpressure
        vq.push_back(mk(1, 1, 4, 0, 0, 0, 1, 24'h0,  0, 0, 24'h0,  1, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 1, 0, 1, 24'h11, 1, 1, 24'h11, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 0, 1, 24'h12, 1, 1, 24'h12, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 0, 0, 24'h13, 0, 0, 24'h0,  0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 0, 0, 24'h13, 0, 0, 24'h0,  0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 0, 1, 24'h13, 1, 1, 24'h13, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 1, 1, 24'h14, 1, 1, 24'h14, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 0, 0, 0, 1, 24'h0,  0, 0, 24'h0,  1, 1, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 0, 0, 0, 1, 24'h0,  0, 0, 24'h0,  1, 0, 1, 0, 0));
        // 1x4 frame, TLAST on the 2nd beat, SOF first held off by a full FIFO
        vq.push_back(mk(1, 1, 4, 0, 0, 0, 1, 24'h0, 0, 0, 24'h0, 1, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 1, 0, 0, 24'hA, 0, 0, 24'h0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 1, 0, 1, 24'hA, 1, 1, 24'hA, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 1, 1, 24'hB, 1, 1, 24'hB, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 0, 1, 24'hC, 0, 1, 24'hB, 1, 0, 0, 1, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 0, 0, 24'hC, 0, 0, 24'h0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 0, 1, 24'hC, 0, 1, 24'hB, 1, 0, 0, 1, 0));
        vq.push_back(mk(0, 1, 4, 0, 0, 0, 1, 24'h0, 0, 0, 24'h0, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 1, 4, 0, 0, 0, 1, 24'h0, 0, 0, 24'h0, 1, 0, 1, 1, 0));

        repeat (3) @(negedge ap_clk);
        #1;
        chk("rst tready", 32'(vif.s_axis_tready), 32'd0);
        chk("rst write",  32'(vif.img_data_stream_write), 32'd0);
        chk("rst din",    32'(vif.img_data_stream_din), 32'd0);
        chk("rst blk_n",  32'(vif.img_data_stream_blk_n), 32'd1);
        chk("rst done",   32'({ap_done, ap_ready}), 32'd0);
        chk("rst idle",   32'(ap_idle), 32'd1);
        chk("rst errs",   32'({err_early_eol, err_late_eol}), 32'd0);
        ap_rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge ap_clk);
            ap_start = vq[i].st; rows = vq[i].r; cols = vq[i].c;
            vif.s_axis_tvalid = vq[i].vld; vif.s_axis_tuser = vq[i].usr;
            vif.s_axis_tlast = vq[i].lst; vif.s_axis_tdata = vq[i].dat;
            vif.img_data_stream_full_n = vq[i].full;
            #4;
            chk($sformatf("v%0d tready", i), 32'(vif.s_axis_tready), 32'(vq[i].e_rdy));
            chk($sformatf("v%0d write", i),  32'(vif.img_data_stream_write), 32'(vq[i].e_wr));
            if (vq[i].e_wr)
                chk($sformatf("v%0d din", i), 32'(vif.img_data_stream_din), 32'(vq[i].e_din));
            chk($sformatf("v%0d blk_n", i),  32'(vif.img_data_stream_blk_n), 32'(vq[i].e_blk));
            chk($sformatf("v%0d done", i),   32'(ap_done), 32'(vq[i].e_done));
            chk($sformatf("v%0d ready", i),  32'(ap_ready), 32'(vq[i].e_done));
            chk($sformatf("v%0d idle", i),   32'(ap_idle), 32'(vq[i].e_idle));
            chk($sformatf("v%0d early", i),  32'(err_early_eol), 32'(vq[i].e_ee));
            chk($sformatf("v%0d late", i),   32'(err_late_eol), 32'(vq[i].e_le));
        end
        vif.img_data_stream_full_n = 1'b1;

        // SOF search: three junk beats, then a 2x2 frame
        rows = 12'd2; cols = 12'd2; wq.delete(); n_acc = 0;
        cyc(1, 0, 0, 0, 24'h0);
        for (int j = 0; j < 3; j++) cyc(0, 1, 0, 0, 24'h900 + 24'(j));
        chk("sof junk accepted", 32'(n_acc), 32'd3);
        chk("sof junk writes", 32'(wq.size()), 32'd0);
        cyc(0, 1, 1, 0, 24'h21); cyc(0, 1, 0, 1, 24'h22);
        cyc(0, 1, 0, 0, 24'h23); cyc(0, 1, 0, 1, 24'h24);
        wait_done("sof", 5);
        exp_sof = '{24'h21, 24'h22, 24'h23, 24'h24};
        chk_writes("sof", exp_sof);
        chk("sof early", 32'(err_early_eol), 32'd0);

        // Late EOL: cols=2, row 0 carries four beats
        wq.delete();
        cyc(1, 0, 0, 0, 24'h0);
        cyc(0, 1, 1, 0, 24'h31); cyc(0, 1, 0, 0, 24'h32);
        cyc(0, 1, 0, 0, 24'h33);
        chk("late drain tready", 32'(last_rdy), 32'd1);
        chk("late drain write",  32'(last_wr), 32'd0);
        cyc(0, 1, 0, 1, 24'h34);
        cyc(0, 1, 0, 0, 24'h35); cyc(0, 1, 0, 1, 24'h36);
        wait_done("late", 5);
        exp_late = '{24'h31, 24'h32, 24'h35, 24'h36};
        chk_writes("late", exp_late);
        chk("late flag", 32'(err_late_eol), 32'd1);
        chk("late early cleared", 32'(err_early_eol), 32'd0);

        // Reset after 3 of 8 pixels, then a complete new frame
        rows = 12'd2; cols = 12'd4; n_done = 0;
        cyc(1, 0, 0, 0, 24'h0);
        cyc(0, 1, 1, 0, 24'h41); cyc(0, 1, 0, 0, 24'h42); cyc(0, 1, 0, 0, 24'h43);
        ap_rst = 1'b1;
        cyc(0, 0, 0, 0, 24'h0);
        ap_rst = 1'b0;
        cyc(0, 1, 0, 0, 24'h44);
        chk("abort idle",   32'(ap_idle), 32'd1);
        chk("abort tready", 32'(last_rdy), 32'd0);
        chk("abort late",   32'(err_late_eol), 32'd0);
        repeat (4) cyc(0, 0, 0, 0, 24'h0);
        chk("abort no done", 32'(n_done), 32'd0);
        wq.delete();
        cyc(1, 0, 0, 0, 24'h0);
        for (int j = 0; j < 8; j++)
            cyc(0, 1, j == 0, (j % 4) == 3, 24'h51 + 24'(j));
        wait_done("rst", 5);
        exp_rst = '{24'h51, 24'h52, 24'h53, 24'h54, 24'h55, 24'h56, 24'h57, 24'h58};
        chk_writes("rst", exp_rst);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
